ifetch_seq32: RTL and testbench
===============================

// Module: ifetch_seq32
// PURPOSE
//  Instruction-fetch stage of the MIPS32 CPU. Holds the PC and fetches each word from
//  instruction memory over a req/ack handshake. Presents Instruction to the control and
//  decode stage, then computes the next PC at commit from Branch/nBranch/Jmp/Jal/Jr/Zero.
//  Provides branch_base_addr (PC+4) to the branch adder and link_addr for jal writeback.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  IMEM_ADDR_W  14             word-address width to instruction memory (64 KB)
//  TIMEOUT      255            max cycles waiting for imem_ack before fetch_err
// PORTS
//  clock             in   1   single system clock, rising edge
//  reset             in   1   synchronous, active-high
//  imem_req          out  1   fetch request, held high until ack
//  imem_addr         out  IMEM_ADDR_W  word address = pc[IMEM_ADDR_W+1:2]
//  imem_ack          in   1   1-cycle pulse: imem_rdata valid this cycle
//  imem_rdata        in   32  fetched instruction word
//  Instruction       out  32  registered instruction to control/decode
//  inst_valid        out  1   Instruction is current and executing
//  commit            out  1   inst_valid & ~stall; gates RegWrite/MemWrite/IOWrite
//  stall             in   1   hold current instruction (extends execute)
//  Branch, nBranch   in   1   beq / bne from control
//  Jmp, Jal, Jr      in   1   jump controls from control
//  Zero              in   1   ALU zero flag
//  Addr_result       in   32  branch target from ALU branch adder
//  Read_data_1       in   32  rs value (jr target)
//  branch_base_addr  out  32  pc + 4 (combinational)
//  link_addr         out  32  registered pc+4 of last committed jal
//  pc                out  32  current PC
//  fetch_err         out  1   sticky: fetch timeout
// BEHAVIOUR
//  Reset (sync, checked at the clock edge): pc=RESET_PC, Instruction=0, link_addr=0,
//   state=S_REQ, wait counter=0, fetch_err=0. imem_req is forced to 0 while reset=1.
//   Reset overrides any state, including an outstanding request. Any late ack is ignored.
//  FSM:
//   S_REQ:  imem_req=1, imem_addr from pc. Counter +1 per cycle.
//           If imem_ack: Instruction<=imem_rdata, counter<=0, go to S_EXEC.
//           If no ack and counter==TIMEOUT: fetch_err<=1, go to S_HALT.
//   S_EXEC: inst_valid=1. If stall: stay; pc, Instruction and link_addr are unchanged.
//           If ~stall (commit=1): pc<=next_pc, go to S_REQ.
//   S_HALT: imem_req=0, inst_valid=0. Leave only on reset.
//  Latency: req->ack N cycles, then 1 execute cycle. Minimum 2 cycles per instruction
//   (ack in the first S_REQ cycle).
//  imem_ack outside S_REQ is ignored. imem_req stays high in S_REQ until ack.
//  next_pc priority, evaluated only at commit:
//   1 Jr: Read_data_1 & ~32'h3
//   2 Jmp|Jal: {pc_plus4[31:28], Instruction[25:0], 2'b00}
//   3 (Branch&Zero)|(nBranch&~Zero): Addr_result & ~32'h3
//   4 otherwise: pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0)
//  Jal at commit: link_addr<=pc+4. Jal and Jr together take Jr; link is still written.
//  Outputs in S_REQ/S_HALT: inst_valid=0, commit=0. Instruction holds its last value.
//  Control inputs are sampled only when commit=1.
// TESTING
//  T1 reset, ack 1 cycle after each req, 3 non-branch words -> imem_addr 0,1,2;
//     commit once per instruction; pc 0,4,8
//  T2 pc=0x10, beq with Zero=1, Addr_result=0x40 -> pc=0x40;
//     same with Zero=0 -> pc=0x14; bne inverts this
//  T3 pc=0x2000_0008, jal with target field 0x0000100 -> pc=0x2000_0400,
//     link_addr=0x2000_000C; jr with Read_data_1=0x0000_0403 -> pc=0x0000_0400
//  T4 stall held 3 cycles in S_EXEC -> inst_valid=1, commit=0, pc unchanged;
//     commit on release; no extra imem_req during stall
//  T5 no ack for TIMEOUT+1 cycles -> fetch_err=1, imem_req=0;
//     later ack ignored; reset clears it and refetches at RESET_PC
//  T6 reset asserted mid-S_REQ and mid-S_EXEC -> next cycle pc=RESET_PC,
//     inst_valid=0, link_addr=0, imem_req=0 during reset

Source files
------------

// File: rtl/ifetch_seq32_if.sv
// Instruction-memory fetch bus: word-addressed request held until a one-cycle ack.
interface ifetch_seq32_if #(
    parameter int ADDR_W = 14
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;

    // fetch stage drives the request, memory answers with ack/rdata
    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_seq32.sv
// MIPS32 instruction-fetch stage: owns the PC, fetches one word per instruction
// over the imem handshake, holds it while execute runs, and picks the next PC at commit.
module ifetch_seq32 #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14,
    parameter int          TIMEOUT     = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    ifetch_seq32_if.master         imem,
    output logic [31:0]            Instruction,
    output logic                   inst_valid,
    output logic                   commit,
    input  logic                   stall,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   Jmp,
    input  logic                   Jal,
    input  logic                   Jr,
    input  logic                   Zero,
    input  logic [31:0]            Addr_result,
    input  logic [31:0]            Read_data_1,
    output logic [31:0]            branch_base_addr,
    output logic [31:0]            link_addr,
    output logic [31:0]            pc,
    output logic                   fetch_err
);

    // counter only has to reach TIMEOUT; keep at least one bit for TIMEOUT=0
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              req_q;
    logic              valid_q;
    logic [31:0]       pc_plus4;
    logic [31:0]       jump_target;
    logic              branch_taken;
    logic [31:0]       next_pc;

    assign pc_plus4         = pc + 32'd4;
    assign branch_base_addr = pc_plus4;
    assign jump_target      = {pc_plus4[31:28], Instruction[25:0], 2'b00};
    assign branch_taken     = (Branch & Zero) | (nBranch & ~Zero);

    // request is a registered FSM output, but reset must kill it in the same cycle
    assign imem.req   = req_q & ~reset;
    assign imem.addr  = pc[IMEM_ADDR_W+1:2];
    assign inst_valid = valid_q;
    assign commit     = valid_q & ~stall;

    // next-PC selection; only consumed on a commit cycle, Jr wins over Jal
    always_comb begin
        next_pc = pc_plus4;
        if (Jr)
            next_pc = Read_data_1 & ~32'h3;
        else if (Jmp | Jal)
            next_pc = jump_target;
        else if (branch_taken)
            next_pc = Addr_result & ~32'h3;
    end

    // fetch/execute FSM with registered request/valid and all architectural state
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_REQ;
            wait_cnt    <= '0;
            req_q       <= 1'b1;
            valid_q     <= 1'b0;
            pc          <= RESET_PC;
            Instruction <= 32'h0;
            link_addr   <= 32'h0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem.ack) begin
                        Instruction <= imem.rdata;
                        wait_cnt    <= '0;
                        req_q       <= 1'b0;
                        valid_q     <= 1'b1;
                        state       <= S_EXEC;
                    end else if (wait_cnt == CNT_LAST) begin
                        // memory never answered: park until reset
                        fetch_err <= 1'b1;
                        req_q     <= 1'b0;
                        state     <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    // a stalled instruction keeps pc, Instruction and link untouched
                    if (!stall) begin
                        pc <= next_pc;
                        if (Jal)
                            link_addr <= pc_plus4;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state   <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_seq32.sv
// Self-checking bench for ifetch_seq32: directed scenarios plus randomized
// instruction streams, checked against a per-instruction PC/link model.
module tb_ifetch_seq32;

    localparam int          TO  = 255;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset, stall, Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0] Addr_result, Read_data_1;
    logic [31:0] Instruction, branch_base_addr, link_addr, pc;
    logic        inst_valid, commit, fetch_err;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_pc, m_link, m_instr;

    ifetch_seq32_if #(.ADDR_W(14)) imem ();

    ifetch_seq32 #(.RESET_PC(RPC), .IMEM_ADDR_W(14), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .imem(imem),
        .Instruction(Instruction), .inst_valid(inst_valid), .commit(commit),
        .stall(stall), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal),
        .Jr(Jr), .Zero(Zero), .Addr_result(Addr_result), .Read_data_1(Read_data_1),
        .branch_base_addr(branch_base_addr), .link_addr(link_addr), .pc(pc),
        .fetch_err(fetch_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    // spec-level next PC: priority Jr, jump, taken branch, sequential
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
        input logic br, nbr, jmp, jal, jr, zero, input logic [31:0] ar, rd1);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (jr) return rd1 & 32'hFFFF_FFFC;
        if (jmp || jal) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if ((br && zero) || (nbr && !zero)) return ar & 32'hFFFF_FFFC;
        return p4;
    endfunction

    task automatic set_ctl(input logic br, nbr, jmp, jal, jr, zero, input logic [31:0] ar, rd1);
        Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Jr = jr; Zero = zero;
        Addr_result = ar; Read_data_1 = rd1;
    endtask

    // called on a negedge; leaves the DUT in S_REQ at a negedge
    task automatic do_reset();
        reset = 1'b1;
        imem.ack = 1'b0;
        #1 chk("rst_req_low", {31'b0, imem.req}, 32'h0);
        @(negedge clock);
        chk("rst_req_low2", {31'b0, imem.req}, 32'h0);
        chk("rst_pc", pc, RPC);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_link", link_addr, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_err", {31'b0, fetch_err}, 32'h0);
        reset = 1'b0;
        m_pc = RPC; m_link = 32'h0; m_instr = 32'h0;
        #1 chk("rst_refetch_req", {31'b0, imem.req}, 32'h1);
        chk("rst_refetch_addr", {18'b0, imem.addr}, {18'b0, RPC[15:2]});
    endtask

    // ack arrives after dly waiting cycles; ends at a negedge in S_EXEC
    task automatic fetch(input logic [31:0] word, input int dly);
        for (int i = 0; i < dly; i++) begin
            chk("wait_req", {31'b0, imem.req}, 32'h1);
            chk("wait_valid", {31'b0, inst_valid}, 32'h0);
            chk("wait_commit", {31'b0, commit}, 32'h0);
            @(negedge clock);
        end
        chk("req", {31'b0, imem.req}, 32'h1);
        chk("addr", {18'b0, imem.addr}, {18'b0, m_pc[15:2]});
        imem.ack = 1'b1; imem.rdata = word;
        @(negedge clock);
        imem.ack = 1'b0; imem.rdata = $urandom;
        m_instr = word;
        chk("exec_valid", {31'b0, inst_valid}, 32'h1);
        chk("exec_instr", Instruction, m_instr);
        chk("exec_pc", pc, m_pc);
        chk("exec_req", {31'b0, imem.req}, 32'h0);
        chk("exec_err", {31'b0, fetch_err}, 32'h0);
    endtask

    // stalls nst cycles with junk controls, then commits with the given controls
    task automatic execute(input int nst, input logic br, nbr, jmp, jal, jr, zero,
                           input logic [31:0] ar, rd1);
        logic [31:0] exp;
        for (int i = 0; i < nst; i++) begin
            stall = 1'b1;
            set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom, $urandom);
            #1 chk("stall_commit", {31'b0, commit}, 32'h0);
            @(negedge clock);
            chk("stall_valid", {31'b0, inst_valid}, 32'h1);
            chk("stall_pc", pc, m_pc);
            chk("stall_req", {31'b0, imem.req}, 32'h0);
            chk("stall_instr", Instruction, m_instr);
            chk("stall_link", link_addr, m_link);
        end
        stall = 1'b0;
        set_ctl(br, nbr, jmp, jal, jr, zero, ar, rd1);
        #1 chk("commit", {31'b0, commit}, 32'h1);
        chk("bbase", branch_base_addr, m_pc + 32'd4);
        exp = model_next(m_pc, m_instr, br, nbr, jmp, jal, jr, zero, ar, rd1);
        @(negedge clock);
        if (jal) m_link = m_pc + 32'd4;
        m_pc = exp;
        set_ctl(0, 0, 0, 0, 0, 0, $urandom, $urandom);
        chk("next_pc", pc, m_pc);
        chk("link", link_addr, m_link);
        chk("req_valid", {31'b0, inst_valid}, 32'h0);
        chk("req_commit", {31'b0, commit}, 32'h0);
        chk("req_again", {31'b0, imem.req}, 32'h1);
    endtask

    task automatic plain(input logic [31:0] w);
        fetch(w, 0);
        execute(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0;
        imem.ack = 1'b0; imem.rdata = 32'h0;
        set_ctl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        m_pc = RPC; m_link = 0; m_instr = 0;
        do_reset();

        // T1: ack one cycle after each req, sequential words
        for (int k = 0; k < 3; k++) begin
            chk("t1_addr", {18'b0, imem.addr}, k);
            fetch(32'h2000_0000 + k, 1);
            chk("t1_pc", pc, 32'(k * 4));
            execute(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        end
        chk("t1_pc_end", pc, 32'hC);

        // T2: beq / bne from pc=0x10
        plain(32'h1111_1111);
        chk("t2_pc10", pc, 32'h10);
        fetch(32'h1000_0000, 0); execute(0, 1, 0, 0, 0, 0, 1, 32'h40, 0);
        chk("t2_beq_taken", pc, 32'h40);
        fetch(32'h0800_0004, 0); execute(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("t2_jmp10", pc, 32'h10);
        fetch(32'h1000_0000, 0); execute(0, 1, 0, 0, 0, 0, 0, 32'h40, 0);
        chk("t2_beq_not", pc, 32'h14);
        fetch(32'h0800_0004, 2); execute(0, 0, 0, 1, 0, 0, 0, 0, 0);
        fetch(32'h1400_0000, 0); execute(0, 0, 1, 0, 0, 0, 0, 32'h40, 0);
        chk("t2_bne_taken", pc, 32'h40);
        fetch(32'h1400_0000, 0); execute(0, 0, 1, 0, 0, 0, 1, 32'h80, 0);
        chk("t2_bne_not", pc, 32'h44);

        // T3: jal / jr in the 0x2xxx_xxxx region
        fetch(32'h0000_0008, 0); execute(0, 0, 0, 0, 0, 1, 0, 0, 32'h2000_000B);
        chk("t3_pc", pc, 32'h2000_0008);
        fetch(32'h0C00_0100, 1); execute(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t3_jal_pc", pc, 32'h2000_0400);
        chk("t3_link", link_addr, 32'h2000_000C);
        fetch(32'h03E0_0008, 0); execute(0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0403);
        chk("t3_jr_pc", pc, 32'h0000_0400);
        // jal+jr together: jr target, link still written
        fetch(32'h0C00_0200, 0); execute(0, 0, 0, 0, 1, 1, 0, 0, 32'h0000_1000);
        chk("t3_jaljr_pc", pc, 32'h0000_1000);
        chk("t3_jaljr_link", link_addr, 32'h0000_0404);

        // pc wrap at the top of the address space
        fetch(32'h0, 0); execute(0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
        plain(32'h2222_2222);
        chk("wrap_pc", pc, 32'h0);

        // T4: three-cycle stall
        fetch(32'h3333_3333, 1); execute(3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_pc", pc, 32'h4);

        // T5: timeout, late ack ignored, reset recovers
        for (int i = 0; i < TO; i++) @(negedge clock);
        chk("t5_err_before", {31'b0, fetch_err}, 32'h0);
        chk("t5_req_before", {31'b0, imem.req}, 32'h1);
        @(negedge clock);
        chk("t5_err", {31'b0, fetch_err}, 32'h1);
        chk("t5_req", {31'b0, imem.req}, 32'h0);
        imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem.ack = 1'b0;
        @(negedge clock);
        chk("t5_late_valid", {31'b0, inst_valid}, 32'h0);
        chk("t5_late_instr", Instruction, m_instr);
        chk("t5_late_err", {31'b0, fetch_err}, 32'h1);
        chk("t5_late_req", {31'b0, imem.req}, 32'h0);
        do_reset();
        plain(32'h4444_4444);

        // T6: reset mid-S_REQ and mid-S_EXEC with nonzero link/pc
        fetch(32'h0C00_0040, 0); execute(0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clock);
        do_reset();
        fetch(32'h0C00_0040, 0); execute(0, 0, 0, 0, 1, 0, 0, 0, 0);
        fetch(32'h5555_5555, 1);
        do_reset();
        chk("t6_link", link_addr, 32'h0);

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            fetch($urandom, $urandom_range(0, 4));
            execute($urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0), 1'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 30) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
